// File: rtl/bubble_buffer_writer_if.sv
// Command/payload handshake and outbuffer bit-write bus for bubble_buffer_writer.
// master: host side (drives START/PAGEMODE/DIN). slave: the writer itself.
interface bubble_buffer_writer_if;
  logic        START;
  logic        PAGEMODE;
  logic [7:0]  DIN;
  logic        DIN_VALID;
  logic        DIN_READY;
  logic [14:0] OUTBUFWADDR;
  logic        OUTBUFWCLK;
  logic        OUTBUFWDATA;
  logic        BUSY;
  logic        DONE;

  modport master (
    output START, PAGEMODE, DIN, DIN_VALID,
    input  DIN_READY, OUTBUFWADDR, OUTBUFWCLK, OUTBUFWDATA, BUSY, DONE
  );

  modport slave (
    input  START, PAGEMODE, DIN, DIN_VALID,
    output DIN_READY, OUTBUFWADDR, OUTBUFWCLK, OUTBUFWDATA, BUSY, DONE
  );
endinterface

// File: rtl/bubble_buffer_writer.sv
// Bubble memory image writer: serializes a boot (480 B) or page (128 B) image
// into the outbuffer as 2-cycle bit writes, optionally surrounded by filler.
// Optional feature: define BUBBLE_WRITER_FILL_EN to emit the filler regions;
// without it the filler states last one cycle each and only payload is written.
//
// state     | meaning
// IDLE      | waiting for START
// FILL_PRE  | filler before the payload region
// LOAD      | accepting bytes and writing payload bits LSB first
// FILL_POST | filler after the payload region
// DONE      | one-cycle completion pulse
module bubble_buffer_writer (
  input  logic                  MCLK,
  input  logic                  RESET,
  bubble_buffer_writer_if.slave bus
);

`ifdef BUBBLE_WRITER_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  // Bit addresses are {location, channel}, so region bounds are 2*location (+1).
  localparam logic [14:0] BOOT_FILL_BASE  = 15'd0;
  localparam logic [14:0] BOOT_PRE_END    = 15'd4105;
  localparam logic [14:0] BOOT_PAY_BASE   = 15'd4106;
  localparam logic [14:0] BOOT_POST_END   = 15'd8211;
  localparam logic [14:0] BOOT_ZERO_LO    = 15'd3974;
  localparam logic [14:0] BOOT_ZERO_HI    = 15'd4100;
  localparam logic [14:0] PAGE_FILL_BASE  = 15'd14336;
  localparam logic [14:0] PAGE_PRE_END    = 15'd14341;
  localparam logic [14:0] PAGE_PAY_BASE   = 15'd14342;
  localparam logic [14:0] PAGE_GAP_LAST   = 15'd15503;
  localparam logic [14:0] PAGE_TAIL_FIRST = 15'd16380;
  localparam logic [14:0] PAGE_POST_END   = 15'd16383;
  localparam logic [8:0]  BOOT_BYTES      = 9'd480;
  localparam logic [8:0]  PAGE_BYTES      = 9'd128;

  typedef enum logic [2:0] {S_IDLE, S_FILL_PRE, S_LOAD, S_FILL_POST, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        page_q, page_d;
  logic [14:0] nxt_q, nxt_d;
  logic [14:0] waddr_q, waddr_d;
  logic        wdata_q, wdata_d;
  logic        wclk_q, wclk_d;
  logic        pa_q, pa_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [3:0]  bits_q, bits_d;
  logic [8:0]  bytes_q, bytes_d;

  logic [14:0] pre_end, post_end, start_base, nxt_inc;
  logic [8:0]  total;
  logic        fill_bit, shreg_empty, ready, take;
  logic        pre_last, post_last, load_last;

  // Region bounds and handshake qualifiers derived from the latched image type.
  always_comb begin
    pre_end     = page_q ? PAGE_PRE_END : BOOT_PRE_END;
    post_end    = page_q ? PAGE_POST_END : BOOT_POST_END;
    total       = page_q ? PAGE_BYTES : BOOT_BYTES;
    if (FILL_EN) start_base = bus.PAGEMODE ? PAGE_FILL_BASE : BOOT_FILL_BASE;
    else         start_base = bus.PAGEMODE ? PAGE_PAY_BASE : BOOT_PAY_BASE;
    // Boot filler is 1 except ch0 of locations 1987-2050; page filler is all 0.
    fill_bit    = !page_q && !(!nxt_q[0] && nxt_q >= BOOT_ZERO_LO && nxt_q <= BOOT_ZERO_HI);
    // Page post-fill skips from location 7751 straight to 8190.
    nxt_inc     = (page_q && nxt_q == PAGE_GAP_LAST) ? PAGE_TAIL_FIRST : nxt_q + 15'd1;
    // Empty means no bits queued and no write phase in flight.
    shreg_empty = (bits_q == 4'd0) && !pa_q && !wclk_q;
    ready       = (state_q == S_LOAD) && shreg_empty && (bytes_q != total);
    take        = ready && bus.DIN_VALID;
    pre_last    = wclk_q && (waddr_q == pre_end);
    post_last   = wclk_q && (waddr_q == post_end);
    load_last   = wclk_q && (bits_q == 4'd0) && (bytes_q == total);
  end

  // State register.
  always_ff @(posedge MCLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; region ends are taken after the final phase B.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (bus.START) state_d = S_FILL_PRE;
      S_FILL_PRE:  if (!FILL_EN || pre_last) state_d = S_LOAD;
      S_LOAD:      if (load_last) state_d = S_FILL_POST;
      S_FILL_POST: if (!FILL_EN || post_last) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath registers: write bus, shift register and counters.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      page_q  <= 1'b0;
      nxt_q   <= '0;
      waddr_q <= '0;
      wdata_q <= 1'b0;
      wclk_q  <= 1'b0;
      pa_q    <= 1'b0;
      shreg_q <= '0;
      bits_q  <= '0;
      bytes_q <= '0;
    end else begin
      page_q  <= page_d;
      nxt_q   <= nxt_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wclk_q  <= wclk_d;
      pa_q    <= pa_d;
      shreg_q <= shreg_d;
      bits_q  <= bits_d;
      bytes_q <= bytes_d;
    end
  end

  // Datapath next values: phase A issues addr/data, phase B raises the write clock.
  always_comb begin
    page_d  = page_q;
    nxt_d   = nxt_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wclk_d  = 1'b0;
    pa_d    = pa_q;
    shreg_d = shreg_q;
    bits_d  = bits_q;
    bytes_d = bytes_q;
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          page_d  = bus.PAGEMODE;
          nxt_d   = start_base;
          pa_d    = 1'b0;
          bits_d  = '0;
          bytes_d = '0;
        end
      end
      S_FILL_PRE, S_FILL_POST: begin
        if (FILL_EN) begin
          if (pa_q) begin
            wclk_d = 1'b1;
            pa_d   = 1'b0;
          end else if (!((state_q == S_FILL_PRE) ? pre_last : post_last)) begin
            waddr_d = nxt_q;
            wdata_d = fill_bit;
            pa_d    = 1'b1;
            nxt_d   = nxt_inc;
          end
        end
      end
      S_LOAD: begin
        if (pa_q) begin
          wclk_d = 1'b1;
          pa_d   = 1'b0;
          bits_d = bits_q - 4'd1;
        end else if (wclk_q && bits_q != 4'd0) begin
          waddr_d = nxt_q;
          wdata_d = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
          pa_d    = 1'b1;
          nxt_d   = nxt_q + 15'd1;
        end else if (take) begin
          waddr_d = nxt_q;
          wdata_d = bus.DIN[0];
          shreg_d = {1'b0, bus.DIN[7:1]};
          bits_d  = 4'd8;
          pa_d    = 1'b1;
          nxt_d   = nxt_q + 15'd1;
          bytes_d = bytes_q + 9'd1;
        end
      end
      default: ;
    endcase
  end

  // Output decode.
  always_comb begin
    bus.DIN_READY   = ready;
    bus.OUTBUFWADDR = waddr_q;
    bus.OUTBUFWDATA = wdata_q;
    bus.OUTBUFWCLK  = wclk_q;
    bus.BUSY        = (state_q != S_IDLE);
    bus.DONE        = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_bubble_buffer_writer.sv
// Bench for bubble_buffer_writer; expectations follow BUBBLE_WRITER_FILL_EN.
module tb_bubble_buffer_writer;
  logic MCLK = 1'b0;
  logic RESET;
  bubble_buffer_writer_if ifc();

  bubble_buffer_writer dut (.MCLK(MCLK), .RESET(RESET), .bus(ifc.slave));

  always #10 MCLK = ~MCLK;

`ifdef BUBBLE_WRITER_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  int          checks = 0;
  int          failures = 0;
  int          cap_a[$];
  bit          cap_d[$];
  int          exp_a[$];
  bit          exp_d[$];
  logic [7:0]  byte_q[$];
  int          done_cnt = 0;
  int          pay_cnt = 0;
  int          pay_lo = 0;
  int          pay_hi = -1;
  logic        prev_wclk = 1'b0;
  logic [14:0] prev_addr = '0;
  logic        prev_data = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Capture every write pulse; each phase B must follow a phase A with the same addr/data.
  always @(negedge MCLK) begin
    if (ifc.OUTBUFWCLK === 1'b1) begin
      check("phase_a_before_b", {prev_wclk, prev_addr, prev_data},
            {1'b0, ifc.OUTBUFWADDR, ifc.OUTBUFWDATA});
      cap_a.push_back(int'(ifc.OUTBUFWADDR));
      cap_d.push_back(ifc.OUTBUFWDATA);
      if (int'(ifc.OUTBUFWADDR) >= pay_lo && int'(ifc.OUTBUFWADDR) <= pay_hi) pay_cnt++;
    end
    if (ifc.DONE === 1'b1) done_cnt++;
    prev_wclk = ifc.OUTBUFWCLK;
    prev_addr = ifc.OUTBUFWADDR;
    prev_data = ifc.OUTBUFWDATA;
  end

  task automatic push(input int a, input bit d);
    exp_a.push_back(a);
    exp_d.push_back(d);
  endtask

  // Expected write list built location by location from the image layout.
  task automatic build_model(input bit page);
    int first;
    logic [7:0] b;
    exp_a.delete();
    exp_d.delete();
    first = page ? 7171 : 2053;
    if (FILL) begin
      if (page) begin
        for (int loc = 7168; loc <= 7170; loc++) begin push(2*loc, 1'b0); push(2*loc+1, 1'b0); end
      end else begin
        for (int loc = 0; loc <= 2052; loc++) begin
          push(2*loc, (loc >= 1987 && loc <= 2050) ? 1'b0 : 1'b1);
          push(2*loc+1, 1'b1);
        end
      end
    end
    for (int n = 0; n < 8*byte_q.size(); n++) begin
      b = byte_q[n/8];
      push(2*first + n, b[n%8]);
    end
    if (FILL) begin
      if (page) begin
        for (int loc = 7683; loc <= 7751; loc++) begin push(2*loc, 1'b0); push(2*loc+1, 1'b0); end
        for (int loc = 8190; loc <= 8191; loc++) begin push(2*loc, 1'b0); push(2*loc+1, 1'b0); end
      end else begin
        for (int loc = 3973; loc <= 4105; loc++) begin push(2*loc, 1'b1); push(2*loc+1, 1'b1); end
      end
    end
    pay_lo = 2*first;
    pay_hi = 2*first + 8*byte_q.size() - 1;
  endtask

  task automatic compare_writes(input string tag, input int n);
    int bad = -1;
    for (int i = 0; i < n; i++)
      if (bad < 0 && (i >= exp_a.size() || cap_a[i] != exp_a[i] || cap_d[i] != exp_d[i])) bad = i;
    check({tag, "_first_bad_write_index"}, bad, -1);
    if (bad >= 0 && bad < exp_a.size())
      check({tag, "_bad_write_addr_data"}, {cap_a[bad], cap_d[bad]}, {exp_a[bad], exp_d[bad]});
  endtask

  // vmode: 0 valid always, 1 random ~70%, 2 toggling every 3 cycles.
  task automatic run_load(input bit page, input int vmode, input int glitch_cyc,
                          input int abort_bits, input string tag);
    int idx = 0;
    int cyc = 0;
    int since = 100;
    int nb;
    int n_before;
    bit v;
    bit acc_pend = 1'b0;
    bit timed_out = 1'b1;
    logic [7:0] last_byte = '0;
    nb = byte_q.size();
    build_model(page);
    cap_a.delete();
    cap_d.delete();
    done_cnt = 0;
    pay_cnt = 0;
    @(negedge MCLK); #1;
    ifc.PAGEMODE = page;
    ifc.START = 1'b1;
    while (cyc < 40000) begin
      @(negedge MCLK); #1;
      cyc++;
      since++;
      ifc.START = (cyc == glitch_cyc);
      ifc.PAGEMODE = ~page;
      if (acc_pend) begin
        check({tag, "_byte_first_phase_a"},
              {ifc.OUTBUFWCLK, ifc.OUTBUFWADDR, ifc.OUTBUFWDATA},
              {1'b0, 15'(pay_lo + 8*(idx-1)), last_byte[0]});
        since = 1;
        acc_pend = 1'b0;
      end
      if (ifc.BUSY !== 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      if (ifc.DIN_READY === 1'b1)
        check({tag, "_ready_empty_bytes_left_wclk_low"},
              {since >= 17, idx < nb, ifc.OUTBUFWCLK}, 3'b110);
      case (vmode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 9) < 7);
        default: v = ((cyc / 3) % 2) == 0;
      endcase
      if (idx >= nb) v = 1'b0;
      ifc.DIN_VALID = v;
      if (v) ifc.DIN = byte_q[idx];
      else   ifc.DIN = 8'($urandom);
      if (v && ifc.DIN_READY === 1'b1) begin
        acc_pend = 1'b1;
        last_byte = byte_q[idx];
        idx++;
      end
      if (abort_bits > 0 && pay_cnt >= abort_bits) begin
        check({tag, "_payload_bits_before_reset"}, pay_cnt, abort_bits);
        RESET = 1'b1;
        ifc.DIN_VALID = 1'b0;
        ifc.START = 1'b0;
        @(negedge MCLK); #1;
        check({tag, "_after_reset_busy_done_ready_wclk"},
              {ifc.BUSY, ifc.DONE, ifc.DIN_READY, ifc.OUTBUFWCLK}, 4'b0000);
        RESET = 1'b0;
        n_before = cap_a.size();
        repeat (40) @(negedge MCLK);
        #1;
        check({tag, "_no_writes_after_reset"}, cap_a.size(), n_before);
        check({tag, "_done_count"}, done_cnt, 0);
        compare_writes(tag, cap_a.size());
        return;
      end
    end
    ifc.START = 1'b0;
    ifc.DIN_VALID = 1'b0;
    check({tag, "_timeout"}, timed_out, 1'b0);
    repeat (3) @(negedge MCLK);
    #1;
    check({tag, "_bytes_taken"}, idx, nb);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_write_count"}, cap_a.size(), exp_a.size());
    compare_writes(tag, cap_a.size());
  endtask

  initial begin
    RESET = 1'b1;
    ifc.START = 1'b0;
    ifc.PAGEMODE = 1'b0;
    ifc.DIN = '0;
    ifc.DIN_VALID = 1'b0;
    repeat (3) @(negedge MCLK);
    #1;
    check("reset_busy_done_ready_wclk_wdata",
          {ifc.BUSY, ifc.DONE, ifc.DIN_READY, ifc.OUTBUFWCLK, ifc.OUTBUFWDATA}, 5'b00000);
    check("reset_waddr", ifc.OUTBUFWADDR, 15'd0);
    RESET = 1'b0;

    // Page image 0x01, 0x00...
    byte_q.delete();
    byte_q.push_back(8'h01);
    repeat (127) byte_q.push_back(8'h00);
    run_load(1'b1, 0, 0, 0, "page_01");
    if (cap_a.size() >= 8) begin
      check("page_01_first_write_addr", cap_a[0], FILL ? 14336 : 14342);
      check("page_01_first_payload_addr_data", {cap_a[FILL ? 6 : 0], cap_d[FILL ? 6 : 0]}, {32'd14342, 1'b1});
      check("page_01_second_payload_addr_data", {cap_a[FILL ? 7 : 1], cap_d[FILL ? 7 : 1]}, {32'd14343, 1'b0});
      check("page_01_last_write_addr_data", {cap_a[cap_a.size()-1], cap_d[cap_d.size()-1]},
            {FILL ? 32'd16383 : 32'd15365, 1'b0});
    end

    // 0xA5 first with DIN_VALID toggling every 3 cycles
    byte_q.delete();
    byte_q.push_back(8'hA5);
    repeat (127) byte_q.push_back(8'($urandom));
    run_load(1'b1, 2, 0, 0, "page_a5");

    // Boot image, random bytes and stalls, START glitch during LOAD
    byte_q.delete();
    repeat (480) byte_q.push_back(8'($urandom));
    run_load(1'b0, 1, FILL ? 8600 : 300, 0, "boot");
    check("boot_total_pulses", cap_a.size(), FILL ? 8212 : 3840);
    if (FILL && cap_a.size() > 3975)
      check("boot_loc1987_writes", {cap_a[3974], cap_d[3974], cap_a[3975], cap_d[3975]},
            {32'd3974, 1'b0, 32'd3975, 1'b1});

    // Reset after 37 payload bits, then a fresh page load
    byte_q.delete();
    repeat (128) byte_q.push_back(8'($urandom));
    run_load(1'b1, 1, 0, 37, "abort");
    run_load(1'b1, 1, 0, 0, "restart");
    if (cap_a.size() > 0) check("restart_first_addr", cap_a[0], FILL ? 14336 : 14342);

    // RESET and START together: START is dropped
    @(negedge MCLK); #1;
    RESET = 1'b1;
    ifc.START = 1'b1;
    ifc.PAGEMODE = 1'b1;
    @(negedge MCLK); #1;
    RESET = 1'b0;
    ifc.START = 1'b0;
    check("reset_with_start_busy", ifc.BUSY, 1'b0);
    repeat (3) @(negedge MCLK);
    #1;
    check("reset_with_start_stays_idle", {ifc.BUSY, ifc.OUTBUFWCLK}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
